p2_period_meter: RTL and testbench
==================================

Name: p2_period_meter

Overview:
- Measures a divided clock (e.g. a clock divider's clockout) in the clockin domain.
- Counts the high and low phase lengths of the incoming signal in clockin cycles.
- Publishes high time, low time and period once per signal cycle, and checks the period against an expected divide ratio.
- Serves as the self-checking receive end for the divider blocks: the divider generates the slow clock, this block measures it.

Parameters:
- CNT_W, 16: width of the phase and period counters.
- SYNC_STAGES, 2: synchronizer flops on sig_in; legal values 0..3; 0 means no synchronizer.

Ports:
- clockin  in  1  system clock; all logic is on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- enable  in  1  measurement enable, level-sensitive.
- sig_in  in  1  signal under measurement.
- expected_period  in  CNT_W  expected period in clockin cycles.
- high_cnt  out  CNT_W  cycles sig was high in the last complete period.
- low_cnt  out  CNT_W  cycles sig was low in the last complete period.
- period  out  CNT_W  high_cnt+low_cnt, saturating at all-ones.
- meas_valid  out  1  one-cycle pulse when new results are published.
- period_ok  out  1  period==expected_period for the last published result.
- timeout  out  1  sticky flag: no edge seen for 2^CNT_W-1 cycles.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset:
  - All outputs, counters and synchronizer flops go to 0.
  - FSM goes to IDLE.
  - Asserting reset mid-measurement discards it with no meas_valid.
- Synchronization and edge detection:
  - sig_s is sig_in delayed by SYNC_STAGES flops.
  - sig_p is sig_s delayed one cycle.
  - rise = sig_s & ~sig_p; fall = ~sig_s & sig_p.
- Counters: hc (high phase) and lc (low phase), each CNT_W bits.
- FSM states:
  - IDLE: hc=lc=0, timeout cleared. enable=1 -> WAIT_RISE.
  - WAIT_RISE: discards the partial first cycle. lc increments each cycle as a stall counter. rise -> HIGH with hc=1, lc=0.
  - HIGH: hc increments each cycle. fall -> LOW with lc=1.
  - LOW: lc increments each cycle. rise -> publish, then HIGH with hc=1, lc=0. Measurement is back-to-back with no gap.
- Publish (registered, in the cycle after rise is seen in LOW):
  - high_cnt=hc, low_cnt=lc.
  - period = min(hc+lc, 2^CNT_W-1), summed at CNT_W+1 bits.
  - period_ok = (period==expected_period).
  - meas_valid=1 for exactly one cycle.
- Latency: a sig_in rising edge produces meas_valid SYNC_STAGES+2 clockin cycles later.
- Counting example: for sig high H cycles and low L cycles, high_cnt=H, low_cnt=L, period=H+L.
- Timeout:
  - Fires if the active counter (hc in HIGH; lc in LOW or WAIT_RISE) reaches 2^CNT_W-1.
  - Effect: timeout=1 (sticky), hc=lc=0, FSM -> WAIT_RISE, no meas_valid.
  - timeout clears only on reset or enable=0.
  - Counters never wrap.
- enable=0 in any state:
  - FSM -> IDLE on the next edge and timeout clears.
  - An in-flight measurement is discarded.
  - high_cnt, low_cnt, period and period_ok retain their last published values.
  - meas_valid stays 0.
- Simultaneous events:
  - enable=0 takes priority over rise/fall and over timeout.
  - Timeout takes priority over an edge in the same cycle.
- expected_period is sampled only at publish and may change at any time.
- A 1-cycle high pulse is legal (hc=1). A 1-cycle low gap is also legal (lc=1).

Test Plan:
- CNT_W=16, SYNC_STAGES=2, sig_in from a divide-by-10 divider (5 high/5 low), expected_period=10, enable=1:
  - first meas_valid follows the second rise;
  - high_cnt=5, low_cnt=5, period=10, period_ok=1;
  - meas_valid repeats every 10 cycles.
- sig_in 3 high/7 low, expected_period=10 -> high_cnt=3, low_cnt=7, period=10, period_ok=1. Then set expected_period=12 -> next pulse has period_ok=0.
- CNT_W=8, sig_in held at 1 after a rise -> timeout=1 exactly 254 cycles after hc=1, no meas_valid. Then a toggle with 4/4 -> meas_valid with period=8 while timeout stays 1. Then enable=0 -> timeout=0.
- Drop enable in the middle of a HIGH phase -> no meas_valid, prior outputs retained. Re-enable -> the first partial cycle is discarded and the first result is a full period.
- Assert resetn=0 asynchronously mid-LOW -> all outputs are 0 immediately (before the next clockin edge). Release -> FSM in IDLE.
- Single-cycle high pulses every 4 cycles -> high_cnt=1, low_cnt=3, period=4; meas_valid lands SYNC_STAGES+2 cycles after each sig_in rise.

Source files
------------

// File: rtl/p2_period_meter.sv
// Measures high time, low time and period of a slow signal in clockin cycles,
// publishing one result per signal cycle and flagging stalls with a sticky timeout.
module p2_period_meter #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2   // 0..3; 0 samples sig_in directly
) (
  input  logic             clockin,
  input  logic             resetn,
  input  logic             enable,
  input  logic             sig_in,
  input  logic [CNT_W-1:0] expected_period,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] low_cnt,
  output logic [CNT_W-1:0] period,
  output logic             meas_valid,
  output logic             period_ok,
  output logic             timeout
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    HIGH      = 2'd2,
    LOW       = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  // A counter sitting here would reach all-ones on its next increment.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_MAX - CNT_ONE;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum[CNT_W]) begin
      sat_add = CNT_MAX;
    end else begin
      sat_add = sum[CNT_W-1:0];
    end
  endfunction

  logic             sig_s;
  logic             sig_p_r;
  logic             rise_s;
  logic             fall_s;
  state_t           state_r;
  logic [CNT_W-1:0] hc_r;
  logic [CNT_W-1:0] lc_r;
  logic             cap_r;
  logic [CNT_W-1:0] cap_hc_r;
  logic [CNT_W-1:0] cap_lc_r;
  logic [CNT_W-1:0] sum_sat_s;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign sig_s = sig_in;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_r;

      // Synchronizer shift chain for the asynchronous input.
      always_ff @(posedge clockin or negedge resetn) begin
        if (!resetn) begin
          sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
          sync_r[0] <= sig_in;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_r[i] <= sync_r[i-1];
          end
        end
      end

      assign sig_s = sync_r[SYNC_STAGES-1];
    end
  endgenerate

  // Previous-cycle copy of the synchronized signal for edge detection.
  always_ff @(posedge clockin or negedge resetn) begin
    if (!resetn) begin
      sig_p_r <= 1'b0;
    end else begin
      sig_p_r <= sig_s;
    end
  end

  assign rise_s    = sig_s & ~sig_p_r;
  assign fall_s    = ~sig_s & sig_p_r;
  assign sum_sat_s = sat_add(cap_hc_r, cap_lc_r);

  // Measurement FSM: phase counters, timeout and capture of finished periods.
  always_ff @(posedge clockin or negedge resetn) begin
    if (!resetn) begin
      state_r  <= IDLE;
      hc_r     <= CNT_ZERO;
      lc_r     <= CNT_ZERO;
      timeout  <= 1'b0;
      cap_r    <= 1'b0;
      cap_hc_r <= CNT_ZERO;
      cap_lc_r <= CNT_ZERO;
    end else if (!enable) begin
      state_r <= IDLE;
      hc_r    <= CNT_ZERO;
      lc_r    <= CNT_ZERO;
      timeout <= 1'b0;
      cap_r   <= 1'b0;
    end else begin
      cap_r <= 1'b0;
      case (state_r)
        IDLE: begin
          hc_r    <= CNT_ZERO;
          lc_r    <= CNT_ZERO;
          timeout <= 1'b0;
          state_r <= WAIT_RISE;
        end
        WAIT_RISE: begin
          // lc doubles as a stall counter until the first full cycle starts.
          if (lc_r == CNT_LAST) begin
            timeout <= 1'b1;
            hc_r    <= CNT_ZERO;
            lc_r    <= CNT_ZERO;
          end else if (rise_s) begin
            state_r <= HIGH;
            hc_r    <= CNT_ONE;
            lc_r    <= CNT_ZERO;
          end else begin
            lc_r <= lc_r + CNT_ONE;
          end
        end
        HIGH: begin
          if (hc_r == CNT_LAST) begin
            timeout <= 1'b1;
            hc_r    <= CNT_ZERO;
            lc_r    <= CNT_ZERO;
            state_r <= WAIT_RISE;
          end else if (fall_s) begin
            state_r <= LOW;
            lc_r    <= CNT_ONE;
          end else begin
            hc_r <= hc_r + CNT_ONE;
          end
        end
        LOW: begin
          if (lc_r == CNT_LAST) begin
            timeout <= 1'b1;
            hc_r    <= CNT_ZERO;
            lc_r    <= CNT_ZERO;
            state_r <= WAIT_RISE;
          end else if (rise_s) begin
            cap_r    <= 1'b1;
            cap_hc_r <= hc_r;
            cap_lc_r <= lc_r;
            state_r  <= HIGH;
            hc_r     <= CNT_ONE;
            lc_r     <= CNT_ZERO;
          end else begin
            lc_r <= lc_r + CNT_ONE;
          end
        end
        default: begin
          state_r <= IDLE;
          hc_r    <= CNT_ZERO;
          lc_r    <= CNT_ZERO;
        end
      endcase
    end
  end

  // Result registers: updated only on publish, otherwise they hold.
  always_ff @(posedge clockin or negedge resetn) begin
    if (!resetn) begin
      high_cnt   <= CNT_ZERO;
      low_cnt    <= CNT_ZERO;
      period     <= CNT_ZERO;
      period_ok  <= 1'b0;
      meas_valid <= 1'b0;
    end else if (cap_r && enable) begin
      high_cnt   <= cap_hc_r;
      low_cnt    <= cap_lc_r;
      period     <= sum_sat_s;
      period_ok  <= (sum_sat_s == expected_period);
      meas_valid <= 1'b1;
    end else begin
      meas_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_p2_period_meter.sv
// Directed bench: a 16-bit meter for the main vectors, an 8-bit meter for
// timeout and saturation corners.
module tb_p2_period_meter;

  logic        clk;
  logic        resetn;
  logic        en_a, sig_a, en_b, sig_b;
  logic [15:0] exp_a, high_a, low_a, period_a;
  logic        mv_a, ok_a, tout_a;
  logic [7:0]  exp_b, high_b, low_b, period_b;
  logic        mv_b, ok_b, tout_b;

  int n_err = 0;
  int n_checks = 0;
  int cyc_n = 0;
  int mva_cnt = 0, mvb_cnt = 0;
  int last_mv_a = 0, prev_mv_a = 0, last_rise_a = 0;

  typedef struct {
    int hi; int lo; int expp;
    int eh; int el; int ep; int eok;
  } vec_t;
  vec_t vecs[6];

  p2_period_meter #(.CNT_W(16), .SYNC_STAGES(2)) dut_a (
    .clockin(clk), .resetn(resetn), .enable(en_a), .sig_in(sig_a),
    .expected_period(exp_a), .high_cnt(high_a), .low_cnt(low_a),
    .period(period_a), .meas_valid(mv_a), .period_ok(ok_a), .timeout(tout_a)
  );

  p2_period_meter #(.CNT_W(8), .SYNC_STAGES(2)) dut_b (
    .clockin(clk), .resetn(resetn), .enable(en_b), .sig_in(sig_b),
    .expected_period(exp_b), .high_cnt(high_b), .low_cnt(low_b),
    .period(period_b), .meas_valid(mv_b), .period_ok(ok_b), .timeout(tout_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Drive both signals for one cycle, then sample just after the edge.
  task automatic cyc(input logic sa, input logic sb);
    if (sa && !sig_a) last_rise_a = cyc_n;
    sig_a = sa;
    sig_b = sb;
    @(posedge clk);
    #1;
    cyc_n++;
    if (mv_a) begin
      mva_cnt++;
      prev_mv_a = last_mv_a;
      last_mv_a = cyc_n;
    end
    if (mv_b) mvb_cnt++;
  endtask

  task automatic run_vec(input int idx);
    int base;
    en_a = 1'b0;
    repeat (2) cyc(1'b0, 1'b0);
    exp_a = 16'(vecs[idx].expp);
    en_a = 1'b1;
    repeat (3) cyc(1'b0, 1'b0);
    base = mva_cnt;
    for (int p = 0; p < 3; p++) begin
      repeat (vecs[idx].hi) cyc(1'b1, 1'b0);
      repeat (vecs[idx].lo) cyc(1'b0, 1'b0);
    end
    repeat (6) cyc(1'b0, 1'b0);
    chk($sformatf("v%0d_count", idx), mva_cnt - base, 2);
    chk($sformatf("v%0d_high", idx), high_a, vecs[idx].eh);
    chk($sformatf("v%0d_low", idx), low_a, vecs[idx].el);
    chk($sformatf("v%0d_period", idx), period_a, vecs[idx].ep);
    chk($sformatf("v%0d_ok", idx), ok_a, vecs[idx].eok);
    chk($sformatf("v%0d_spacing", idx), last_mv_a - prev_mv_a, vecs[idx].hi + vecs[idx].lo);
    chk($sformatf("v%0d_latency", idx), last_mv_a - last_rise_a, 4);
  endtask

  initial begin
    int base, t0, tout_at;
    vecs[0] = '{hi: 5, lo: 5, expp: 10, eh: 5, el: 5, ep: 10, eok: 1};
    vecs[1] = '{hi: 3, lo: 7, expp: 10, eh: 3, el: 7, ep: 10, eok: 1};
    vecs[2] = '{hi: 3, lo: 7, expp: 12, eh: 3, el: 7, ep: 10, eok: 0};
    vecs[3] = '{hi: 1, lo: 3, expp: 4,  eh: 1, el: 3, ep: 4,  eok: 1};
    vecs[4] = '{hi: 2, lo: 1, expp: 3,  eh: 2, el: 1, ep: 3,  eok: 1};
    vecs[5] = '{hi: 7, lo: 2, expp: 5,  eh: 7, el: 2, ep: 9,  eok: 0};

    resetn = 1'b0; en_a = 1'b0; en_b = 1'b0; sig_a = 1'b0; sig_b = 1'b0;
    exp_a = 16'd0; exp_b = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_high", high_a, 0);
    chk("rst_low", low_a, 0);
    chk("rst_period", period_a, 0);
    chk("rst_mv", mv_a, 0);
    chk("rst_ok", ok_a, 0);
    chk("rst_tout", tout_a, 0);
    chk("rst_period_b", period_b, 0);
    chk("rst_tout_b", tout_b, 0);
    resetn = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(i);

    // Enable dropped mid-HIGH: nothing published, results held.
    en_a = 1'b0;
    repeat (2) cyc(1'b0, 1'b0);
    exp_a = 16'd8;
    en_a = 1'b1;
    repeat (3) cyc(1'b0, 1'b0);
    repeat (4) cyc(1'b1, 1'b0);
    base = mva_cnt;
    en_a = 1'b0;
    repeat (3) cyc(1'b1, 1'b0);
    chk("dis_no_mv", mva_cnt - base, 0);
    chk("dis_high", high_a, 7);
    chk("dis_low", low_a, 2);
    chk("dis_period", period_a, 9);
    chk("dis_ok", ok_a, 0);
    en_a = 1'b1;
    repeat (2) cyc(1'b1, 1'b0);
    repeat (4) cyc(1'b0, 1'b0);
    repeat (4) cyc(1'b1, 1'b0);
    repeat (4) cyc(1'b0, 1'b0);
    repeat (4) cyc(1'b1, 1'b0);
    repeat (6) cyc(1'b0, 1'b0);
    chk("reen_count", mva_cnt - base, 1);
    chk("reen_high", high_a, 4);
    chk("reen_low", low_a, 4);
    chk("reen_period", period_a, 8);
    chk("reen_ok", ok_a, 1);

    // Asynchronous reset in the LOW phase, checked before the next edge.
    #3;
    resetn = 1'b0;
    #1;
    chk("arst_high", high_a, 0);
    chk("arst_low", low_a, 0);
    chk("arst_period", period_a, 0);
    chk("arst_mv", mv_a, 0);
    chk("arst_ok", ok_a, 0);
    chk("arst_tout", tout_a, 0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    exp_a = 16'd10;
    base = mva_cnt;
    repeat (3) cyc(1'b0, 1'b0);
    for (int p = 0; p < 3; p++) begin
      repeat (5) cyc(1'b1, 1'b0);
      repeat (5) cyc(1'b0, 1'b0);
    end
    repeat (6) cyc(1'b0, 1'b0);
    chk("post_rst_count", mva_cnt - base, 2);
    chk("post_rst_high", high_a, 5);
    chk("post_rst_low", low_a, 5);
    chk("post_rst_period", period_a, 10);
    chk("post_rst_ok", ok_a, 1);

    // 8-bit meter: signal stuck high after a rise.
    en_b = 1'b1;
    exp_b = 8'd8;
    repeat (3) cyc(1'b0, 1'b0);
    t0 = cyc_n;
    tout_at = -1;
    for (int k = 0; k < 300; k++) begin
      cyc(1'b0, 1'b1);
      if (tout_b && tout_at < 0) tout_at = cyc_n;
    end
    chk("tout_time", tout_at, t0 + 257);
    chk("tout_no_mv", mvb_cnt, 0);
    chk("tout_sticky", tout_b, 1);
    base = mvb_cnt;
    for (int p = 0; p < 2; p++) begin
      repeat (4) cyc(1'b0, 1'b0);
      repeat (4) cyc(1'b0, 1'b1);
    end
    repeat (6) cyc(1'b0, 1'b0);
    chk("tog_count", mvb_cnt - base, 1);
    chk("tog_high", high_b, 4);
    chk("tog_low", low_b, 4);
    chk("tog_period", period_b, 8);
    chk("tog_ok", ok_b, 1);
    chk("tog_tout", tout_b, 1);
    en_b = 1'b0;
    cyc(1'b0, 1'b0);
    chk("tout_clear", tout_b, 0);
    chk("tout_hold_period", period_b, 8);

    // 200 + 100 exceeds 8 bits: period saturates.
    en_b = 1'b1;
    exp_b = 8'd255;
    repeat (3) cyc(1'b0, 1'b0);
    base = mvb_cnt;
    repeat (200) cyc(1'b0, 1'b1);
    repeat (100) cyc(1'b0, 1'b0);
    repeat (5) cyc(1'b0, 1'b1);
    repeat (6) cyc(1'b0, 1'b0);
    chk("sat_count", mvb_cnt - base, 1);
    chk("sat_high", high_b, 200);
    chk("sat_low", low_b, 100);
    chk("sat_period", period_b, 255);
    chk("sat_ok", ok_b, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
